// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_pkg
//  Description : Shared configuration, state encoding and per-layer geometry
//                helpers for the dense-stack weight sequencer.
//                LNN entries are listed in literal order, so LNN[0] is the
//                first value of the list; layer k has LNN[N-1-k] nerves.
//  Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

    localparam int DNN_NUM_LAYERS     = 4;
    localparam int DNN_MAX_NUM_NERVES = 6;
    localparam int DNN_M_W_BIT_SIZE   = 16;
    localparam int DNN_IMAGE_SIZE     = 16;

    typedef int lnn_t [DNN_NUM_LAYERS];
    localparam lnn_t DNN_LNN = '{2, 3, 5, 6};

    // Row counter must hold the largest per-layer row count.
    localparam int ROW_W = $clog2(((DNN_IMAGE_SIZE > DNN_MAX_NUM_NERVES) ?
                                   DNN_IMAGE_SIZE : DNN_MAX_NUM_NERVES) + 1);
    // Layer counter runs one past the last layer at the end of a load.
    localparam int LAY_W = $clog2(DNN_NUM_LAYERS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rows fed to layer k equal the output count of layer k-1.
    function automatic int rows_of(input int k, input int image_size, input lnn_t lnn);
        int r;
        if (k == 0) r = image_size;
        else        r = lnn[DNN_NUM_LAYERS - k];
        return r;
    endfunction

    function automatic int lanes_of(input int k, input lnn_t lnn);
        return lnn[DNN_NUM_LAYERS - 1 - k];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dnn_lane_mask.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_lane_mask
//  Description : Combinational lane mask. Keeps the top i_lane_cnt lanes of a
//                weight row and drives the remaining low lanes to zero.
//  Ports       : i_row      - input weight row
//                i_lane_cnt - number of active (MSB) lanes
//                o_row      - masked weight row
//  Revision    : 1.0 - initial release
// ============================================================================
module dnn_lane_mask #(
    parameter int N_LANES = 6,
    parameter int LANE_W  = 16,
    parameter int CNT_W   = 3
) (
    input  logic [N_LANES-1:0][LANE_W-1:0] i_row,
    input  logic [CNT_W-1:0]               i_lane_cnt,
    output logic [N_LANES-1:0][LANE_W-1:0] o_row
);

    always_comb begin
        o_row = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (i >= (N_LANES - int'(i_lane_cnt))) o_row[i] = i_row[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dnn_weight_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_weight_sequencer
//  Description : Handshaked, stallable, abortable weight-row loader for the
//                dense stack. Routes each accepted row to the layer being
//                loaded with a one-hot enable and per-layer lane masking.
//  Ports       : clk, res_n        - clock, synchronous active-low reset
//                in_start/in_abort - (re)load request / cancel load
//                in_w_valid/in_weights, out_w_ready - row input handshake
//                out_w_en/out_w_valid/out_weights/out_row - registered row out
//                out_busy/out_loaded/out_done - status
//  Revision    : 1.0 - initial release
// ============================================================================
module dnn_weight_sequencer
    import dnn_pkg::*;
#(
    parameter int   NUM_LAYERS     = DNN_NUM_LAYERS,
    parameter int   MAX_NUM_NERVES = DNN_MAX_NUM_NERVES,
    parameter int   M_W_BIT_SIZE   = DNN_M_W_BIT_SIZE,
    parameter int   IMAGE_SIZE     = DNN_IMAGE_SIZE,
    parameter lnn_t LNN            = DNN_LNN
) (
    input  logic                                       clk,
    input  logic                                       res_n,
    input  logic                                       in_start,
    input  logic                                       in_abort,
    input  logic                                       in_w_valid,
    input  logic [MAX_NUM_NERVES-1:0][M_W_BIT_SIZE-1:0] in_weights,
    output logic                                       out_w_ready,
    output logic [NUM_LAYERS-1:0]                      out_w_en,
    output logic                                       out_w_valid,
    output logic [MAX_NUM_NERVES-1:0][M_W_BIT_SIZE-1:0] out_weights,
    output logic [ROW_W-1:0]                           out_row,
    output logic                                       out_busy,
    output logic                                       out_loaded,
    output logic                                       out_done
);

    localparam int c_lane_w = $clog2(MAX_NUM_NERVES + 1);
    localparam int c_idx_w  = $clog2(NUM_LAYERS);

    state_t                                     r_state;
    state_t                                     w_next_state;
    logic [ROW_W-1:0]                           r_row;
    logic [LAY_W-1:0]                           r_layer;
    logic                                       r_loaded;
    logic                                       r_w_valid;
    logic [NUM_LAYERS-1:0]                      r_w_en;
    logic [MAX_NUM_NERVES-1:0][M_W_BIT_SIZE-1:0] r_weights;
    logic [ROW_W-1:0]                           r_out_row;
    logic                                       r_done;

    logic                                       w_ready;
    logic                                       w_xfer;
    logic                                       w_accept;
    logic                                       w_row_last;
    logic                                       w_last_layer;
    logic [c_idx_w-1:0]                         w_lay_idx;
    logic [ROW_W-1:0]                           w_last_row_tbl [NUM_LAYERS];
    logic [c_lane_w-1:0]                        w_lanes_tbl    [NUM_LAYERS];
    logic [MAX_NUM_NERVES-1:0][M_W_BIT_SIZE-1:0] w_masked;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer_tbl
        assign w_last_row_tbl[k] = ROW_W'(rows_of(k, IMAGE_SIZE, LNN) - 1);
        assign w_lanes_tbl[k]    = c_lane_w'(lanes_of(k, LNN));
    end

    // Layer counter reaches NUM_LAYERS only after the load completes, when
    // the truncated index is no longer consumed.
    assign w_lay_idx    = r_layer[c_idx_w-1:0];
    assign w_row_last   = (r_row == w_last_row_tbl[w_lay_idx]);
    assign w_last_layer = (r_layer == LAY_W'(NUM_LAYERS - 1));
    assign w_xfer       = in_w_valid && w_ready;
    // A row moved in the abort cycle is dropped.
    assign w_accept     = w_xfer && !in_abort;

    dnn_lane_mask #(
        .N_LANES (MAX_NUM_NERVES),
        .LANE_W  (M_W_BIT_SIZE),
        .CNT_W   (c_lane_w)
    ) u_lane_mask (
        .i_row      (in_weights),
        .i_lane_cnt (w_lanes_tbl[w_lay_idx]),
        .o_row      (w_masked)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!res_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_start) w_next_state = LOAD;
            LOAD: begin
                if (in_abort)                                w_next_state = IDLE;
                else if (w_xfer && w_last_layer && w_row_last) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            LOAD:    w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Counters and registered row output
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_row     <= '0;
            r_layer   <= '0;
            r_loaded  <= 1'b0;
            r_w_valid <= 1'b0;
            r_w_en    <= '0;
            r_weights <= '0;
            r_out_row <= '0;
            r_done    <= 1'b0;
        end else begin
            r_w_valid <= w_accept;
            r_w_en    <= w_accept ? (NUM_LAYERS'(1) << w_lay_idx) : '0;
            r_done    <= w_accept && w_last_layer && w_row_last;
            if (w_accept) begin
                r_weights <= w_masked;
                r_out_row <= r_row;
            end
            case (r_state)
                IDLE: begin
                    if (in_start) begin
                        r_row    <= '0;
                        r_layer  <= '0;
                        r_loaded <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_abort) begin
                        r_row   <= '0;
                        r_layer <= '0;
                    end else if (w_xfer) begin
                        if (w_row_last) begin
                            r_row   <= '0;
                            r_layer <= r_layer + LAY_W'(1);
                            if (w_last_layer) r_loaded <= 1'b1;
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_w_ready = w_ready;
    assign out_busy    = w_ready;
    assign out_w_en    = r_w_en;
    assign out_w_valid = r_w_valid;
    assign out_weights = r_weights;
    assign out_row     = r_out_row;
    assign out_loaded  = r_loaded;
    assign out_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dnn_weight_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dnn_weight_sequencer
//  Description : Directed self-checking bench for dnn_weight_sequencer with
//                default configuration (16/6/5/3 rows, 6/5/3/2 lanes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dnn_weight_sequencer;

    typedef logic [5:0][15:0] row_t;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       in_start = 1'b0;
    logic       in_abort = 1'b0;
    logic       in_w_valid = 1'b0;
    row_t       in_weights = '0;
    logic       out_w_ready;
    logic [3:0] out_w_en;
    logic       out_w_valid;
    row_t       out_weights;
    logic [4:0] out_row;
    logic       out_busy;
    logic       out_loaded;
    logic       out_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dnn_weight_sequencer dut (
        .clk         (clk),
        .res_n       (res_n),
        .in_start    (in_start),
        .in_abort    (in_abort),
        .in_w_valid  (in_w_valid),
        .in_weights  (in_weights),
        .out_w_ready (out_w_ready),
        .out_w_en    (out_w_en),
        .out_w_valid (out_w_valid),
        .out_weights (out_weights),
        .out_row     (out_row),
        .out_busy    (out_busy),
        .out_loaded  (out_loaded),
        .out_done    (out_done)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic row_t mk_row(input int n);
        row_t r;
        for (int i = 0; i < 6; i++) r[i] = 16'(n * 16 + i + 1);
        return r;
    endfunction

    function automatic row_t exp_w(input int lanes, input row_t w);
        row_t r;
        for (int i = 0; i < 6; i++) r[i] = (i >= 6 - lanes) ? w[i] : 16'h0;
        return r;
    endfunction

    task automatic test_reset();
        res_n = 1'b0;
        step();
        step();
        checks++;
        if ({out_w_ready, out_w_en, out_w_valid, out_weights, out_row,
             out_busy, out_loaded, out_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b v=%b rdy=%b busy=%b ld=%b dn=%b row=%0d w=%h required all 0",
                     out_w_en, out_w_valid, out_w_ready, out_busy, out_loaded, out_done, out_row, out_weights);
        end
        res_n = 1'b1;
        step();
        checks++;
        if (out_busy !== 1'b0 || out_w_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b ready=%b required 0 0", out_busy, out_w_ready);
        end
    endtask

    task automatic test_full_load();
        row_t w;
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        checks++;
        if (out_busy !== 1'b1 || out_w_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_entry: busy=%b ready=%b required 1 1", out_busy, out_w_ready);
        end
        for (int n = 0; n < 30; n++) begin
            int lay;
            int row;
            int lanes;
            if (n < 16)      begin lay = 0; row = n;      lanes = 6; end
            else if (n < 22) begin lay = 1; row = n - 16; lanes = 5; end
            else if (n < 27) begin lay = 2; row = n - 22; lanes = 3; end
            else             begin lay = 3; row = n - 27; lanes = 2; end
            w = (lay == 3) ? {6{16'hFFFF}} : mk_row(n);
            in_w_valid = 1'b1;
            in_weights = w;
            step();
            checks++;
            if (out_w_valid !== 1'b1 || out_w_en !== 4'(1 << lay) || out_row !== 5'(row)) begin
                failures++;
                $display("FAIL full_ctrl n=%0d: got v=%b en=%b row=%0d required v=1 en=%b row=%0d",
                         n, out_w_valid, out_w_en, out_row, 4'(1 << lay), row);
            end
            checks++;
            if (out_weights !== exp_w(lanes, w)) begin
                failures++;
                $display("FAIL full_weights n=%0d: got %h required %h", n, out_weights, exp_w(lanes, w));
            end
            if (lay == 0) begin
                checks++;
                if (out_weights !== w) begin
                    failures++;
                    $display("FAIL mask_layer0 n=%0d: got %h required %h", n, out_weights, w);
                end
            end
            if (lay == 3) begin
                checks++;
                if (out_weights !== {16'hFFFF, 16'hFFFF, 64'h0}) begin
                    failures++;
                    $display("FAIL mask_layer3 n=%0d: got %h required ffffffff0000000000000000", n, out_weights);
                end
            end
            checks++;
            if (out_done !== (n == 29)) begin
                failures++;
                $display("FAIL done_pulse n=%0d: got %b required %b", n, out_done, (n == 29));
            end
        end
        // Start during the DONE cycle must be ignored.
        in_w_valid = 1'b0;
        in_start   = 1'b1;
        step();
        in_start = 1'b0;
        checks++;
        if (out_busy !== 1'b0 || out_w_valid !== 1'b0 || out_w_en !== 4'b0 ||
            out_done !== 1'b0 || out_loaded !== 1'b1) begin
            failures++;
            $display("FAIL after_done: busy=%b v=%b en=%b done=%b loaded=%b required 0 0 0000 0 1",
                     out_busy, out_w_valid, out_w_en, out_done, out_loaded);
        end
        step();
        checks++;
        if (out_busy !== 1'b0 || out_loaded !== 1'b1) begin
            failures++;
            $display("FAIL start_in_done: busy=%b loaded=%b required 0 1", out_busy, out_loaded);
        end
    endtask

    task automatic test_stall();
        int n_valid = 0;
        int exp_row = 0;
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        checks++;
        if (out_loaded !== 1'b0) begin
            failures++;
            $display("FAIL loaded_clear_on_start: got %b required 0", out_loaded);
        end
        for (int n = 0; n < 16; n++) begin
            in_w_valid = 1'b1;
            in_weights = mk_row(n);
            step();
        end
        for (int c = 0; c < 12; c++) begin
            in_w_valid = (c % 2 == 0);
            in_weights = mk_row(100 + c);
            step();
            checks++;
            if (out_w_valid === 1'b1) begin
                if (out_row !== 5'(exp_row) || out_w_en !== 4'b0010) begin
                    failures++;
                    $display("FAIL stall_row c=%0d: got row=%0d en=%b required row=%0d en=0010",
                             c, out_row, out_w_en, exp_row);
                end
                exp_row++;
                n_valid++;
            end else if (out_w_en !== 4'b0000 || (c % 2) == 0) begin
                failures++;
                $display("FAIL stall_idle c=%0d: got v=%b en=%b required v=%b", c, out_w_valid, out_w_en, (c % 2 == 0));
            end
        end
        checks++;
        if (n_valid != 6) begin
            failures++;
            $display("FAIL stall_count: got %0d required 6", n_valid);
        end
        in_w_valid = 1'b0;
        in_abort   = 1'b1;
        step();
        in_abort = 1'b0;
    endtask

    task automatic test_abort();
        int stray = 0;
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            in_w_valid = 1'b1;
            in_weights = mk_row(n);
            step();
        end
        checks++;
        if (out_row !== 5'd3 || out_w_en !== 4'b0010) begin
            failures++;
            $display("FAIL pre_abort: got row=%0d en=%b required row=3 en=0010", out_row, out_w_en);
        end
        in_abort = 1'b1;
        step();
        in_abort = 1'b0;
        checks++;
        if (out_busy !== 1'b0 || out_loaded !== 1'b0 || out_w_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort: busy=%b loaded=%b v=%b required 0 0 0", out_busy, out_loaded, out_w_valid);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (out_w_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_stray: got %0d valid outputs required 0", stray);
        end
        in_w_valid = 1'b0;
        in_start   = 1'b1;
        step();
        in_start   = 1'b0;
        in_w_valid = 1'b1;
        in_weights = mk_row(7);
        step();
        checks++;
        if (out_w_valid !== 1'b1 || out_row !== 5'd0 || out_w_en !== 4'b0001 || out_weights !== mk_row(7)) begin
            failures++;
            $display("FAIL restart: got v=%b row=%0d en=%b w=%h required v=1 row=0 en=0001 w=%h",
                     out_w_valid, out_row, out_w_en, out_weights, mk_row(7));
        end
        in_w_valid = 1'b0;
        in_abort   = 1'b1;
        step();
        in_abort = 1'b0;
    endtask

    task automatic test_start_abort();
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            in_w_valid = 1'b1;
            in_weights = mk_row(n);
            step();
        end
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        checks++;
        if (out_row !== 5'd5 || out_w_en !== 4'b0001 || out_busy !== 1'b1) begin
            failures++;
            $display("FAIL start_in_load: got row=%0d en=%b busy=%b required row=5 en=0001 busy=1",
                     out_row, out_w_en, out_busy);
        end
        step();
        checks++;
        if (out_row !== 5'd6) begin
            failures++;
            $display("FAIL start_in_load_next: got row=%0d required 6", out_row);
        end
        in_w_valid = 1'b0;
        in_start   = 1'b1;
        in_abort   = 1'b1;
        step();
        in_start = 1'b0;
        in_abort = 1'b0;
        checks++;
        if (out_busy !== 1'b0 || out_w_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_abort: busy=%b v=%b required 0 0", out_busy, out_w_valid);
        end
        step();
        checks++;
        if (out_busy !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_hold: busy=%b required 0", out_busy);
        end
    endtask

    task automatic test_reset_midload();
        int n_valid = 0;
        int n_done  = 0;
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        for (int n = 0; n < 24; n++) begin
            in_w_valid = 1'b1;
            in_weights = mk_row(n);
            step();
        end
        res_n = 1'b0;
        step();
        checks++;
        if ({out_w_ready, out_w_en, out_w_valid, out_weights, out_row,
             out_busy, out_loaded, out_done} !== '0) begin
            failures++;
            $display("FAIL midload_reset: got en=%b v=%b rdy=%b busy=%b row=%0d w=%h required all 0",
                     out_w_en, out_w_valid, out_w_ready, out_busy, out_row, out_weights);
        end
        res_n      = 1'b1;
        in_w_valid = 1'b0;
        step();
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            in_w_valid = 1'b1;
            in_weights = mk_row(n);
            step();
            if (out_w_valid === 1'b1) n_valid++;
            if (out_done === 1'b1) n_done++;
        end
        in_w_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (out_w_valid === 1'b1) n_valid++;
            if (out_done === 1'b1) n_done++;
        end
        checks++;
        if (n_valid != 30 || n_done != 1 || out_loaded !== 1'b1) begin
            failures++;
            $display("FAIL reload_after_reset: got valid=%0d done=%0d loaded=%b required 30 1 1",
                     n_valid, n_done, out_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stall();
        test_abort();
        test_start_abort();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
